// File: rtl/square_tone_scheduler_if.sv
// Control and sample bundle between the sound-model CPU/latch side and the
// square tone scheduler. master drives stimulus/config, slave is the scheduler.
interface square_tone_scheduler_if #(
    parameter int unsigned PERIOD_WIDTH   = 24,
    parameter int unsigned DURATION_WIDTH = 16
);
    logic                      audio_clk_en;
    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [PERIOD_WIDTH-1:0]   cfg_half_period;
    logic                      trigger;
    logic [DURATION_WIDTH-1:0] duration;
    logic                      gate;
    logic                      busy;
    logic                      level;
    logic signed [15:0]        out_raw;

    modport master (
        output audio_clk_en,
        output cfg_valid,
        output cfg_half_period,
        output trigger,
        output duration,
        output gate,
        input  cfg_ready,
        input  busy,
        input  level,
        input  out_raw
    );

    modport slave (
        input  audio_clk_en,
        input  cfg_valid,
        input  cfg_half_period,
        input  trigger,
        input  duration,
        input  gate,
        output cfg_ready,
        output busy,
        output level,
        output out_raw
    );
endinterface

// File: rtl/square_tone_scheduler.sv
// Square-wave tone sequencer: start/stop/retrigger, timed or gated length,
// and half-period changes applied only on half-period boundaries.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_IDLE      | silent, level held at 0, config applied immediately
//   ST_RUN       | oscillating; watching duration count or gate for a stop
//   ST_STOP      | oscillating until the current low half completes
module square_tone_scheduler #(
    parameter int unsigned DEFAULT_HALF_PERIOD = 50000,
    parameter int unsigned PERIOD_WIDTH        = 24,
    parameter int unsigned DURATION_WIDTH      = 16,
    parameter int          AMPLITUDE           = 16384
) (
    input logic                    clk,
    input logic                    I_RSTn,
    square_tone_scheduler_if.slave tone
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    localparam logic [PERIOD_WIDTH-1:0] HALF_RESET = PERIOD_WIDTH'(DEFAULT_HALF_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] HALF_MIN   = PERIOD_WIDTH'(2);
    localparam logic signed [15:0]      AMP_HIGH   = 16'(AMPLITUDE);

    logic [1:0]                state;
    logic                      level_q;
    logic signed [15:0]        out_raw_q;
    logic [PERIOD_WIDTH-1:0]   half_cnt;
    logic [PERIOD_WIDTH-1:0]   active_half;
    logic [PERIOD_WIDTH-1:0]   pending_half;
    logic                      pending_full;
    logic [DURATION_WIDTH-1:0] dur_cnt;
    logic                      gate_mode;

    logic                      running;
    logic                      boundary;
    logic                      accept;
    logic [PERIOD_WIDTH-1:0]   cfg_clamped;
    logic                      stop_cond;
    logic                      end_of_tone;

    assign running     = (state != ST_IDLE);
    // active_half is never below 2, so the subtraction cannot wrap
    assign boundary    = running && (half_cnt == (active_half - 1'b1));
    assign accept      = tone.cfg_valid && !pending_full;
    assign cfg_clamped = (tone.cfg_half_period < HALF_MIN) ? HALF_MIN : tone.cfg_half_period;

    assign stop_cond   = (state == ST_RUN) &&
                         (gate_mode ? !tone.gate
                                    : (tone.audio_clk_en && (dur_cnt == DURATION_WIDTH'(1))));
    // The tone only ends where a low half would hand over to a high half.
    assign end_of_tone = (state == ST_STOP) && boundary && !level_q;

    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            state        <= ST_IDLE;
            level_q      <= 1'b0;
            out_raw_q    <= '0;
            half_cnt     <= '0;
            active_half  <= HALF_RESET;
            pending_half <= '0;
            pending_full <= 1'b0;
            dur_cnt      <= '0;
            gate_mode    <= 1'b0;
        end else begin
            // An accept and an apply never coincide: accept needs the slot empty.
            if (accept) begin
                pending_half <= cfg_clamped;
                pending_full <= 1'b1;
            end else if (pending_full && (!running || boundary)) begin
                active_half  <= pending_half;
                pending_full <= 1'b0;
            end

            if (tone.audio_clk_en) begin
                out_raw_q <= level_q ? AMP_HIGH : 16'sd0;
            end

            if (!running) begin
                if (tone.trigger) begin
                    state     <= ST_RUN;
                    level_q   <= 1'b1;
                    half_cnt  <= '0;
                    dur_cnt   <= tone.duration;
                    gate_mode <= (tone.duration == '0);
                end
            end else begin
                half_cnt <= boundary ? '0 : half_cnt + 1'b1;

                if (tone.trigger) begin
                    // Retrigger reloads length only; phase and level carry on.
                    state     <= ST_RUN;
                    dur_cnt   <= tone.duration;
                    gate_mode <= (tone.duration == '0);
                    if (boundary) begin
                        level_q <= !level_q;
                    end
                end else begin
                    if (end_of_tone) begin
                        state <= ST_IDLE;
                    end else if (boundary) begin
                        level_q <= !level_q;
                    end

                    if ((state == ST_RUN) && tone.audio_clk_en && (dur_cnt != '0)) begin
                        dur_cnt <= dur_cnt - 1'b1;
                    end
                    if (stop_cond) begin
                        state <= ST_STOP;
                    end
                end
            end
        end
    end

    assign tone.cfg_ready = !pending_full;
    assign tone.busy      = running;
    assign tone.level     = level_q;
    assign tone.out_raw   = out_raw_q;
endmodule
